cpu_step_ctrl: RTL and testbench

Parametrised run-control sequencer that sits between the board clock/reset and the `procesadorArm` core. It produces a stretched processor reset and a per-cycle clock enable. It supports free-run, single-step and N-cycle burst modes, so the core can be stepped deterministically in hardware and in simulation instead of toggling `clk` by hand. It also exposes an enabled-cycle counter for debug and VGA overlay.

---
 rtl/cpu_step_ctrl.sv | 178 +++++++++++++++++
 tb/tb_cpu_step_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_step_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_step_ctrl
//
// Run-control sequencer placed between the board clock/reset and the core.
// It produces a stretched synchronous reset for the core and a per-cycle
// clock enable, so the core can run freely, single-step, or run a counted
// burst of N enabled cycles. It also counts enabled cycles for debug display.
//
// Parameters:
//   RST_HOLD  rising edges cpu_rst stays high after reset release or a soft
//             reset (>= 1)
//   CNT_W     width of burst_len and cycle_cnt
//
// Ports:
//   clk        in   system clock, all logic on the rising edge
//   rst        in   asynchronous active-low reset
//   mode       in   2'b00 halt, 2'b01 step, 2'b10 burst, 2'b11 run
//   start      in   operation request, sampled only in IDLE
//   burst_len  in   enabled-cycle count for burst, sampled with start
//   soft_rst   in   synchronous request to re-reset the core
//   cpu_rst    out  synchronous active-high reset to the core
//   cpu_en     out  core clock enable
//   busy       out  high whenever the state is not IDLE
//   done       out  one-cycle pulse when a step, burst or run completes
//   cycle_cnt  out  cycles with cpu_en=1 since the last core reset
//   state_dbg  out  current FSM state (RESET=0, IDLE=1, ACTIVE=2, FREE=3)
//
// Handshake: there is no ready/acknowledge. start is a plain level that is
// accepted only on an edge where the block is in IDLE; in any other state it
// is dropped, never queued. busy tells the requester when start will be seen.
// ---------------------------------------------------------------------------
module cpu_step_ctrl #(
    parameter int RST_HOLD = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             soft_rst,
    output logic             cpu_rst,
    output logic             cpu_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [1:0]       state_dbg
);

    localparam logic [1:0] ST_RESET  = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;
    localparam logic [1:0] ST_FREE   = 2'd3;

    localparam logic [1:0] MODE_HALT  = 2'b00;
    localparam logic [1:0] MODE_STEP  = 2'b01;
    localparam logic [1:0] MODE_BURST = 2'b10;
    localparam logic [1:0] MODE_RUN   = 2'b11;

    // Hold counter must be able to reach RST_HOLD itself.
    localparam int HOLD_W = (RST_HOLD < 1) ? 1 : $clog2(RST_HOLD + 1);

    localparam logic [HOLD_W-1:0] HOLD_ONE  = 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = 1;

    logic [1:0]        state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [CNT_W-1:0]  remaining;

    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_RESET;
            cpu_rst   <= 1'b1;
            cpu_en    <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            cycle_cnt <= '0;
            hold_cnt  <= '0;
            remaining <= '0;
        end else if (soft_rst) begin
            // Aborts whatever is in flight; an aborted operation never
            // reports done.
            state     <= ST_RESET;
            cpu_rst   <= 1'b1;
            cpu_en    <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            cycle_cnt <= '0;
            hold_cnt  <= '0;
            remaining <= '0;
        end else begin
            done <= 1'b0;

            // Counts the cycle that the core actually executed on this edge.
            if (cpu_en) begin
                cycle_cnt <= cycle_cnt + CNT_ONE;
            end

            case (state)
                ST_RESET: begin
                    hold_cnt <= hold_cnt + HOLD_ONE;
                    if (hold_cnt == HOLD_LAST) begin
                        cpu_rst <= 1'b0;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end

                ST_IDLE: begin
                    if (start) begin
                        case (mode)
                            MODE_STEP: begin
                                remaining <= CNT_ONE;
                                cpu_en    <= 1'b1;
                                busy      <= 1'b1;
                                state     <= ST_ACTIVE;
                            end
                            MODE_BURST: begin
                                if (burst_len == '0) begin
                                    // Empty burst completes at once.
                                    done <= 1'b1;
                                end else begin
                                    remaining <= burst_len;
                                    cpu_en    <= 1'b1;
                                    busy      <= 1'b1;
                                    state     <= ST_ACTIVE;
                                end
                            end
                            MODE_RUN: begin
                                cpu_en <= 1'b1;
                                busy   <= 1'b1;
                                state  <= ST_FREE;
                            end
                            MODE_HALT: begin
                                // Halt ignores start entirely.
                            end
                            default: begin
                            end
                        endcase
                    end
                end

                ST_ACTIVE: begin
                    // mode is deliberately not looked at here.
                    if (cpu_en) begin
                        remaining <= remaining - CNT_ONE;
                        if (remaining == CNT_ONE) begin
                            cpu_en <= 1'b0;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            state  <= ST_IDLE;
                        end
                    end
                end

                ST_FREE: begin
                    if (mode != MODE_RUN) begin
                        cpu_en <= 1'b0;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end

                default: begin
                    state   <= ST_RESET;
                    cpu_rst <= 1'b1;
                    cpu_en  <= 1'b0;
                    busy    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
module tb_cpu_step_ctrl;

    localparam logic [1:0] ST_RESET  = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;
    localparam logic [1:0] ST_FREE   = 2'd3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance, CNT_W = 16
    logic        rst, start, soft_rst;
    logic [1:0]  mode;
    logic [15:0] burst_len;
    logic        cpu_rst, cpu_en, busy, done;
    logic [15:0] cycle_cnt;
    logic [1:0]  state_dbg;

    // narrow instance, CNT_W = 4, for wrap checks
    logic        rst4, start4, soft_rst4;
    logic [1:0]  mode4;
    logic [3:0]  burst_len4;
    logic        cpu_rst4, cpu_en4, busy4, done4;
    logic [3:0]  cycle_cnt4;
    logic [1:0]  state_dbg4;

    cpu_step_ctrl #(.RST_HOLD(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .mode(mode), .start(start),
        .burst_len(burst_len), .soft_rst(soft_rst),
        .cpu_rst(cpu_rst), .cpu_en(cpu_en), .busy(busy), .done(done),
        .cycle_cnt(cycle_cnt), .state_dbg(state_dbg)
    );

    cpu_step_ctrl #(.RST_HOLD(2), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst4), .mode(mode4), .start(start4),
        .burst_len(burst_len4), .soft_rst(soft_rst4),
        .cpu_rst(cpu_rst4), .cpu_en(cpu_en4), .busy(busy4), .done(done4),
        .cycle_cnt(cycle_cnt4), .state_dbg(state_dbg4)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full snapshot of the main instance outputs.
    task automatic check_all(input string tag, input logic e_rst, input logic e_en,
                             input logic e_busy, input logic e_done,
                             input logic [15:0] e_cnt, input logic [1:0] e_st);
        check({tag, ".cpu_rst"}, {31'd0, cpu_rst}, {31'd0, e_rst});
        check({tag, ".cpu_en"},  {31'd0, cpu_en},  {31'd0, e_en});
        check({tag, ".busy"},    {31'd0, busy},    {31'd0, e_busy});
        check({tag, ".done"},    {31'd0, done},    {31'd0, e_done});
        check({tag, ".cnt"},     {16'd0, cycle_cnt}, {16'd0, e_cnt});
        check({tag, ".state"},   {30'd0, state_dbg}, {30'd0, e_st});
    endtask

    // ---------------- driver ----------------
    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; mode = 2'b00; start = 1'b0; burst_len = 16'd0; soft_rst = 1'b0;
        rst4 = 1'b0; mode4 = 2'b00; start4 = 1'b0; burst_len4 = 4'd0; soft_rst4 = 1'b0;

        // Power-on: asynchronous reset takes effect before any edge.
        #2 rst = 1'b0;
        #1 check_all("por_async", 1, 0, 1, 0, 0, ST_RESET);
        tick(); tick(); tick();
        check_all("por_held", 1, 0, 1, 0, 0, ST_RESET);
        rst = 1'b1;
        tick();
        check_all("rel_edge1", 1, 0, 1, 0, 0, ST_RESET);
        tick();
        check_all("rel_edge2", 0, 0, 0, 0, 0, ST_IDLE);

        // Halt mode ignores start.
        mode = 2'b00; start = 1'b1;
        tick();
        check_all("halt_start", 0, 0, 0, 0, 0, ST_IDLE);
        start = 1'b0;

        // Three single steps.
        for (int i = 1; i <= 3; i++) begin
            mode = 2'b01; start = 1'b1;
            tick();
            check_all("step_en", 0, 1, 1, 0, 16'(i - 1), ST_ACTIVE);
            start = 1'b0;
            tick();
            check_all("step_done", 0, 0, 0, 1, 16'(i), ST_IDLE);
            tick();
            check_all("step_after", 0, 0, 0, 0, 16'(i), ST_IDLE);
        end

        // Burst of 5: enables on 5 cycles, done on the 6th.
        mode = 2'b10; burst_len = 16'd5; start = 1'b1;
        tick();
        check_all("b5_start", 0, 1, 1, 0, 3, ST_ACTIVE);
        start = 1'b0;
        mode = 2'b00; // ignored while counting
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_all("b5_mid", 0, 1, 1, 0, 16'(3 + i), ST_ACTIVE);
        end
        tick();
        check_all("b5_done", 0, 0, 0, 1, 8, ST_IDLE);
        tick();
        check_all("b5_after", 0, 0, 0, 0, 8, ST_IDLE);

        // Empty burst: done one cycle after start, no enable.
        mode = 2'b10; burst_len = 16'd0; start = 1'b1;
        tick();
        check_all("b0_done", 0, 0, 0, 1, 8, ST_IDLE);
        start = 1'b0;
        tick();
        check_all("b0_after", 0, 0, 0, 0, 8, ST_IDLE);

        // Free run for 20 enabled cycles, with a start pulse mid-run.
        mode = 2'b11; start = 1'b1;
        tick();
        check_all("run_start", 0, 1, 1, 0, 8, ST_FREE);
        start = 1'b0;
        for (int i = 1; i <= 19; i++) begin
            start = (i == 10);
            tick();
            check_all("run_mid", 0, 1, 1, 0, 16'(8 + i), ST_FREE);
        end
        start = 1'b0;
        mode = 2'b00;
        tick();
        check_all("run_done", 0, 0, 0, 1, 28, ST_IDLE);
        tick();
        check_all("run_after", 0, 0, 0, 0, 28, ST_IDLE);

        // Soft reset in the middle of a burst of 10.
        mode = 2'b10; burst_len = 16'd10; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 4; i++) tick();
        check_all("sr_before", 0, 1, 1, 0, 32, ST_ACTIVE);
        soft_rst = 1'b1;
        tick();
        check_all("sr_hit", 1, 0, 1, 0, 0, ST_RESET);
        soft_rst = 1'b0;
        tick();
        check_all("sr_hold1", 1, 0, 1, 0, 0, ST_RESET);
        tick();
        check_all("sr_rel", 0, 0, 0, 0, 0, ST_IDLE);
        tick();
        check_all("sr_nodone", 0, 0, 0, 0, 0, ST_IDLE);

        // soft_rst and start together: reset wins; held soft_rst stays in RESET.
        mode = 2'b01; start = 1'b1; soft_rst = 1'b1;
        tick();
        check_all("sr_vs_start", 1, 0, 1, 0, 0, ST_RESET);
        start = 1'b0;
        tick(); tick(); tick();
        check_all("sr_held", 1, 0, 1, 0, 0, ST_RESET);
        soft_rst = 1'b0;
        tick();
        check_all("sr2_hold1", 1, 0, 1, 0, 0, ST_RESET);
        tick();
        check_all("sr2_rel", 0, 0, 0, 0, 0, ST_IDLE);

        // Async reset mid-run, between edges.
        mode = 2'b11; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        check_all("ar_running", 0, 1, 1, 0, 2, ST_FREE);
        #2 rst = 1'b0;
        #1 check_all("ar_async", 1, 0, 1, 0, 0, ST_RESET);
        mode = 2'b00;
        tick();
        rst = 1'b1;

        // Narrow counter: 17-cycle run wraps to 1, then a max burst of 15.
        rst4 = 1'b1;
        tick(); tick();
        check("w_idle", {30'd0, state_dbg4}, {30'd0, ST_IDLE});
        check("w_rst", {31'd0, cpu_rst4}, 32'd0);
        mode4 = 2'b11; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int i = 1; i <= 16; i++) tick();
        check("w_run_en", {31'd0, cpu_en4}, 32'd1);
        check("w_run_cnt", {28'd0, cycle_cnt4}, 32'd0);
        mode4 = 2'b00;
        tick();
        check("w_run_done", {31'd0, done4}, 32'd1);
        check("w_run_wrap", {28'd0, cycle_cnt4}, 32'd1);
        tick();
        mode4 = 2'b10; burst_len4 = 4'd15; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int i = 1; i <= 14; i++) tick();
        check("w_b15_en", {31'd0, cpu_en4}, 32'd1);
        check("w_b15_busy", {31'd0, busy4}, 32'd1);
        tick();
        check("w_b15_done", {31'd0, done4}, 32'd1);
        check("w_b15_en_off", {31'd0, cpu_en4}, 32'd0);
        check("w_b15_cnt", {28'd0, cycle_cnt4}, 32'd0);
        check("w_b15_state", {30'd0, state_dbg4}, {30'd0, ST_IDLE});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
